// File: rtl/slave2wb_pipe.sv
// ---------------------------------------------------------------------------
// slave2wb_pipe
//
// Bridges a pipelined Wishbone slave port onto a simple request/grant core
// interface with in-order responses. Each Wishbone strobe is forwarded to the
// core as a request; it is accepted (wb_stall low) only in a cycle where the
// core grants it. Up to MAX_OUT requests may be outstanding. Core responses
// are registered and returned as wb_ack / wb_err one cycle later.
//
// If the Wishbone master drops wb_cyc while responses are still pending, the
// bridge enters FLUSH: it stalls the bus and silently drains the stale
// responses so that a following bus cycle never sees them. A response that
// arrives with nothing outstanding is ignored and raises the sticky
// proto_err flag.
//
// Parameters
//   DW       data width in bits (multiple of 8, >= 8)
//   AW       Wishbone word-address width
//   MAX_OUT  maximum outstanding core requests (>= 1)
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   wb_cyc/stb/we/adr/sel/dat_i   Wishbone request inputs
//   wb_dat_o/ack/err/stall        Wishbone response outputs
//   core_req/we/addr/be/wdata     core request outputs (addr is a byte address)
//   core_gnt                      core accepted the request this cycle
//   core_rvalid/rdata/err         in-order core response
//   proto_err                     sticky: response with nothing outstanding
// ---------------------------------------------------------------------------
module slave2wb_pipe #(
  parameter int DW      = 32,
  parameter int AW      = 30,
  parameter int MAX_OUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 wb_cyc,
  input  logic                 wb_stb,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_adr,
  input  logic [DW/8-1:0]      wb_sel,
  input  logic [DW-1:0]        wb_dat_i,
  output logic [DW-1:0]        wb_dat_o,
  output logic                 wb_ack,
  output logic                 wb_err,
  output logic                 wb_stall,

  output logic                 core_req,
  output logic                 core_we,
  output logic [AW+$clog2(DW/8)-1:0] core_addr,
  output logic [DW/8-1:0]      core_be,
  output logic [DW-1:0]        core_wdata,
  input  logic                 core_gnt,
  input  logic                 core_rvalid,
  input  logic [DW-1:0]        core_rdata,
  input  logic                 core_err,

  output logic                 proto_err
);

  localparam int OFF = $clog2(DW/8);
  localparam int CW  = $clog2(MAX_OUT+1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   out_cnt, cnt_nxt;
  logic            flushing;
  logic            grant;
  logic            resp;
  logic            deliver;
  logic            spurious;

  // Stage p1: registered response towards the Wishbone master
  logic            ack_p1;
  logic            err_p1;
  logic [DW-1:0]   dat_p1;
  logic            perr_p1;

  // -------------------------------------------------------------------------
  // Request path (combinational pass-through)
  // -------------------------------------------------------------------------
  assign flushing   = (state == FLUSH);
  assign core_req   = wb_cyc & wb_stb & ~flushing & (out_cnt < CW'(MAX_OUT));
  assign grant      = core_req & core_gnt;
  assign wb_stall   = ~grant;
  assign core_we    = wb_we;
  assign core_be    = wb_sel;
  assign core_wdata = wb_dat_i;
  assign core_addr  = (AW+OFF)'(wb_adr) << OFF;

  // A response only retires an entry when one is outstanding; otherwise it
  // is a protocol violation and leaves the count untouched.
  assign resp       = core_rvalid & (out_cnt != '0);
  assign spurious   = core_rvalid & (out_cnt == '0);
  assign deliver    = resp & wb_cyc & ~flushing;

  always_comb begin
    cnt_nxt = out_cnt;
    if (grant & ~resp) begin
      cnt_nxt = out_cnt + CW'(1);
    end else if (~grant & resp) begin
      cnt_nxt = out_cnt - CW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Transaction state: IDLE / BUSY track whether anything is outstanding,
  // FLUSH drains responses that belong to an aborted bus cycle.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, BUSY: begin
        if (cnt_nxt == '0) begin
          state_nxt = IDLE;
        end else if (!wb_cyc) begin
          state_nxt = FLUSH;
        end else begin
          state_nxt = BUSY;
        end
      end
      FLUSH: begin
        if (cnt_nxt == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      out_cnt <= '0;
    end else begin
      state   <= state_nxt;
      out_cnt <= cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p0 -> p1: response register (one cycle latency from core_rvalid)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_p1  <= 1'b0;
      err_p1  <= 1'b0;
      dat_p1  <= '0;
      perr_p1 <= 1'b0;
    end else begin
      ack_p1 <= deliver & ~core_err;
      err_p1 <= deliver & core_err;
      if (deliver) begin
        dat_p1 <= core_rdata;
      end
      if (spurious) begin
        perr_p1 <= 1'b1;
      end
    end
  end

  assign wb_ack    = ack_p1;
  assign wb_err    = err_p1;
  assign wb_dat_o  = dat_p1;
  assign proto_err = perr_p1;

endmodule
